tick_timer: RTL and testbench

//  Parametrised successor to the fixed 100 ms -> 1 s pulse chain. Divides clk into base ticks of
//  CLK_DIV cycles, then counts a run-time programmable number of base ticks and emits a done pulse.

---
 rtl/tick_timer.sv | 193 +++++++++++++++++++
 tb/tb_tick_timer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
//   Programmable base-tick timer. A prescaler divides clk into base ticks of
//   CLK_DIV cycles; a down-counter then counts a run-time programmable number
//   of base ticks and pulses done on expiry. One-shot or periodic operation,
//   pause via enable, abort via stop, and the remaining count is readable.
//   Drives the game countdown, display refresh and beeper cadence.
//
// Parameters
//   CLK_DIV     clk cycles per base tick (>= 1)
//   CNT_W       width of period / remaining
//   WARN_TICKS  warn threshold in base ticks (only with TICK_TIMER_WARN_EN)
//
// Ports
//   clk        in   1      system clock, posedge
//   rst        in   1      synchronous reset, active-high
//   enable     in   1      1 = count, 0 = freeze prescaler and remaining
//   start      in   1      strobe: latch period/mode, clear prescaler, run
//   stop       in   1      strobe: abort to idle without done
//   mode       in   1      0 = one-shot, 1 = periodic (latched at start)
//   period     in   CNT_W  base ticks per done pulse (latched at start)
//   tick       out  1      registered pulse per base tick while running
//   done       out  1      registered pulse when remaining expires
//   busy       out  1      1 while running
//   remaining  out  CNT_W  base ticks left in the current period
//   warn       out  1      only with TICK_TIMER_WARN_EN: busy and
//                          0 < remaining <= WARN_TICKS
//
// Build option
//   TICK_TIMER_WARN_EN  define to add the registered warn output.
// -----------------------------------------------------------------------------
module tick_timer #(
    parameter int unsigned CLK_DIV    = 10_000_000,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned WARN_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
`ifdef TICK_TIMER_WARN_EN
    ,
    output logic             warn
`endif
);

    // Prescaler is at least one bit wide so CLK_DIV=1 still elaborates.
    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    // Elaboration-time sanity checks on the parameter set.
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("tick_timer: CLK_DIV must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("tick_timer: CNT_W must be >= 1");
    end
    if (64'(WARN_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_warn_ticks
        $error("tick_timer: WARN_TICKS must fit in CNT_W bits");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic               mode_q, mode_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   rem_q, rem_d;

    logic               start_ok_c;
    logic               wrap_c;

    // A start with a zero period is treated as if it never happened.
    assign start_ok_c = start && (period != '0);

    // Base-tick boundary: only counts while running and enabled.
    assign wrap_c = (state_q == S_RUN) && enable && (pre_q == PRE_LAST);

    // Next-state and next-output logic; priority stop > start > wrap.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        per_d   = per_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        rem_d   = rem_q;

        if (stop) begin
            // Abort: a coincident wrap or start is discarded.
            state_d = S_IDLE;
            pre_d   = '0;
            busy_d  = 1'b0;
            rem_d   = '0;
        end else if (start_ok_c) begin
            // (Re)start from the new period; a coincident wrap is discarded.
            state_d = S_RUN;
            pre_d   = '0;
            per_d   = period;
            mode_d  = mode;
            busy_d  = 1'b1;
            rem_d   = period;
        end else if ((state_q == S_RUN) && enable) begin
            if (wrap_c) begin
                pre_d  = '0;
                tick_d = 1'b1;
                if (rem_q > CNT_W'(1)) begin
                    rem_d = rem_q - CNT_W'(1);
                end else if (rem_q == CNT_W'(1)) begin
                    done_d = 1'b1;
                    if (mode_q) begin
                        rem_d = per_q;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        rem_d   = '0;
                    end
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            per_q  <= '0;
            mode_q <= 1'b0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            rem_q  <= '0;
        end else begin
            pre_q  <= pre_d;
            per_q  <= per_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
            done_q <= done_d;
            busy_q <= busy_d;
            rem_q  <= rem_d;
        end
    end

    assign tick      = tick_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign remaining = rem_q;

`ifdef TICK_TIMER_WARN_EN
    logic warn_q, warn_d;

    // Computed from next-cycle values so warn lines up with remaining.
    always_comb begin
        warn_d = busy_d && (rem_d != '0) && (rem_d <= CNT_W'(WARN_TICKS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn = warn_q;
`endif

endmodule

// File: tb/tb_tick_timer.sv
// -----------------------------------------------------------------------------
// tb_tick_timer
//   Directed bench for tick_timer with CLK_DIV=4, CNT_W=8, WARN_TICKS=2.
//   Edge numbering "+k" counts clock edges after the start edge; outputs are
//   sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_tick_timer;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned WARN_TICKS = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] period;
    logic             tick;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] remaining;
`ifdef TICK_TIMER_WARN_EN
    logic             warn;
`endif

    int vectors     = 0;
    int miscompares = 0;

    tick_timer #(
        .CLK_DIV   (CLK_DIV),
        .CNT_W     (CNT_W),
        .WARN_TICKS(WARN_TICKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .period   (period),
        .tick     (tick),
        .done     (done),
        .busy     (busy),
        .remaining(remaining)
`ifdef TICK_TIMER_WARN_EN
        ,
        .warn     (warn)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] p, input logic m);
        period = p;
        mode   = m;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        logic [CNT_W+2:0] exp;
        rst = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0;
        mode = 1'b0; period = '0;
        step(); step();
        exp = {1'b0, 1'b0, 1'b0, CNT_W'(0)};
        vectors++;
        if ({tick, done, busy, remaining} !== exp) begin
            miscompares++;
            $display("FAIL reset_init got %b expected %b", {tick, done, busy, remaining}, exp);
        end
`ifdef TICK_TIMER_WARN_EN
        vectors++;
        if (warn !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_warn got %b expected 0", warn);
        end
`endif
        rst = 1'b0;
        do_start(8'd5, 1'b0);
        step(); step(); step();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if ({tick, done, busy, remaining} !== exp) begin
                miscompares++;
                $display("FAIL reset_midrun cyc=%0d got %b expected %b", k,
                         {tick, done, busy, remaining}, exp);
            end
        end
        rst = 1'b0;
        step();
        vectors++;
        if ({tick, done, busy, remaining} !== exp) begin
            miscompares++;
            $display("FAIL reset_release got %b expected %b", {tick, done, busy, remaining}, exp);
        end
    endtask

    task automatic test_one_shot();
        logic [CNT_W+2:0] exp;
        logic [CNT_W-1:0] r;
        do_start(8'd3, 1'b0);
        exp = {1'b0, 1'b0, 1'b1, CNT_W'(3)};
        vectors++;
        if ({tick, done, busy, remaining} !== exp) begin
            miscompares++;
            $display("FAIL oneshot +0 got %b expected %b", {tick, done, busy, remaining}, exp);
        end
        for (int k = 1; k <= 14; k++) begin
            step();
            r = (k < 4) ? 8'd3 : (k < 8) ? 8'd2 : (k < 12) ? 8'd1 : 8'd0;
            exp = {(k == 4 || k == 8 || k == 12), (k == 12), (k < 12), r};
            vectors++;
            if ({tick, done, busy, remaining} !== exp) begin
                miscompares++;
                $display("FAIL oneshot +%0d got %b expected %b", k,
                         {tick, done, busy, remaining}, exp);
            end
        end
    endtask

    task automatic test_periodic();
        logic [CNT_W+2:0] exp;
        logic [CNT_W-1:0] r;
        do_start(8'd2, 1'b1);
        // Changing inputs after start must not matter.
        period = 8'd7;
        mode   = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step();
            r = ((k % 8) >= 4) ? 8'd1 : 8'd2;
            exp = {(k % 4 == 0), (k % 8 == 0), 1'b1, r};
            vectors++;
            if ({tick, done, busy, remaining} !== exp) begin
                miscompares++;
                $display("FAIL periodic +%0d got %b expected %b", k,
                         {tick, done, busy, remaining}, exp);
            end
        end
        do_stop();
        exp = {1'b0, 1'b0, 1'b0, CNT_W'(0)};
        vectors++;
        if ({tick, done, busy, remaining} !== exp) begin
            miscompares++;
            $display("FAIL periodic_stop got %b expected %b", {tick, done, busy, remaining}, exp);
        end
    endtask

    task automatic test_pause();
        logic [CNT_W+2:0] exp;
        logic [CNT_W-1:0] r;
        do_start(8'd3, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            enable = !(k >= 7 && k <= 11);
            step();
            r = (k < 4) ? 8'd3 : (k < 13) ? 8'd2 : 8'd1;
            exp = {(k == 4 || k == 13), 1'b0, 1'b1, r};
            vectors++;
            if ({tick, done, busy, remaining} !== exp) begin
                miscompares++;
                $display("FAIL pause +%0d got %b expected %b", k,
                         {tick, done, busy, remaining}, exp);
            end
        end
        enable = 1'b1;
        do_stop();
    endtask

    task automatic test_collisions();
        logic [CNT_W+2:0] exp;
        logic [CNT_W-1:0] r;
        // stop and start together while idle
        period = 8'd3; mode = 1'b0; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, CNT_W'(0)};
        vectors++;
        if ({tick, done, busy, remaining} !== exp) begin
            miscompares++;
            $display("FAIL start_stop_idle got %b expected %b", {tick, done, busy, remaining}, exp);
        end
        // zero-period start while idle
        do_start(8'd0, 1'b1);
        vectors++;
        if ({tick, done, busy, remaining} !== exp) begin
            miscompares++;
            $display("FAIL zero_period_idle got %b expected %b", {tick, done, busy, remaining}, exp);
        end
        // zero-period start while running is ignored; counting continues
        do_start(8'd3, 1'b0);
        step(); step();
        do_start(8'd0, 1'b1);
        exp = {1'b0, 1'b0, 1'b1, CNT_W'(3)};
        vectors++;
        if ({tick, done, busy, remaining} !== exp) begin
            miscompares++;
            $display("FAIL zero_period_run +3 got %b expected %b", {tick, done, busy, remaining}, exp);
        end
        step();
        exp = {1'b1, 1'b0, 1'b1, CNT_W'(2)};
        vectors++;
        if ({tick, done, busy, remaining} !== exp) begin
            miscompares++;
            $display("FAIL zero_period_run +4 got %b expected %b", {tick, done, busy, remaining}, exp);
        end
        do_stop();
        // start in the expiry cycle: restart wins, no done
        do_start(8'd1, 1'b0);
        step(); step(); step();
        do_start(8'd5, 1'b0);
        exp = {1'b0, 1'b0, 1'b1, CNT_W'(5)};
        vectors++;
        if ({tick, done, busy, remaining} !== exp) begin
            miscompares++;
            $display("FAIL start_at_expiry got %b expected %b", {tick, done, busy, remaining}, exp);
        end
        for (int k = 5; k <= 8; k++) begin
            step();
            r = (k < 8) ? 8'd5 : 8'd4;
            exp = {(k == 8), 1'b0, 1'b1, r};
            vectors++;
            if ({tick, done, busy, remaining} !== exp) begin
                miscompares++;
                $display("FAIL after_restart +%0d got %b expected %b", k,
                         {tick, done, busy, remaining}, exp);
            end
        end
        do_stop();
        // stop in the expiry cycle: no done
        do_start(8'd1, 1'b0);
        step(); step(); step();
        do_stop();
        exp = {1'b0, 1'b0, 1'b0, CNT_W'(0)};
        vectors++;
        if ({tick, done, busy, remaining} !== exp) begin
            miscompares++;
            $display("FAIL stop_at_expiry got %b expected %b", {tick, done, busy, remaining}, exp);
        end
        step();
        vectors++;
        if ({tick, done, busy, remaining} !== exp) begin
            miscompares++;
            $display("FAIL stop_at_expiry+1 got %b expected %b", {tick, done, busy, remaining}, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W+2:0] exp;
        logic [CNT_W-1:0] r;
        do_start(8'd3, 1'b1);
        for (int k = 1; k <= 6; k++) step();
        do_start(8'd2, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            r = (k < 4) ? 8'd2 : (k < 8) ? 8'd1 : 8'd2;
            exp = {(k % 4 == 0), (k == 8), 1'b1, r};
            vectors++;
            if ({tick, done, busy, remaining} !== exp) begin
                miscompares++;
                $display("FAIL back_to_back +%0d got %b expected %b", k,
                         {tick, done, busy, remaining}, exp);
            end
        end
        do_stop();
    endtask

`ifdef TICK_TIMER_WARN_EN
    task automatic test_warn();
        logic [CNT_W+3:0] exp;
        logic [CNT_W-1:0] r;
        do_start(8'd4, 1'b0);
        vectors++;
        if (warn !== 1'b0) begin
            miscompares++;
            $display("FAIL warn +0 got %b expected 0", warn);
        end
        for (int k = 1; k <= 17; k++) begin
            step();
            r = (k < 4) ? 8'd4 : (k < 8) ? 8'd3 : (k < 12) ? 8'd2 : (k < 16) ? 8'd1 : 8'd0;
            exp = {(k >= 8 && k < 16), (k % 4 == 0 && k <= 16), (k == 16), (k < 16), r};
            vectors++;
            if ({warn, tick, done, busy, remaining} !== exp) begin
                miscompares++;
                $display("FAIL warn +%0d got %b expected %b", k,
                         {warn, tick, done, busy, remaining}, exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_pause();
        test_collisions();
        test_back_to_back();
`ifdef TICK_TIMER_WARN_EN
        test_warn();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired after %0d vectors, required completion", vectors);
        $fatal(1);
    end

endmodule
